// File: rtl/bip_control.sv
// BIP processor control unit: fetch/decode/execute sequencer with PC and cycle counter.
// Drives the accumulator mux, ALU controls and data-memory strobes from state and IR.
module bip_control #(
    parameter int unsigned PC_W  = 11,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      instr_data,
    output logic [PC_W-1:0]  prog_addr,
    output logic [PC_W-1:0]  data_addr,
    output logic             rd_ram,
    output logic             wr_ram,
    output logic [1:0]       sel_a,
    output logic             sel_b,
    output logic             op,
    output logic             wr_acc,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycles
);

    localparam int unsigned OPC_W = 5;
    localparam int unsigned OPR_W = 11;

    localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PC_W-1:0]    r_pc;
    logic [15:0]        r_ir;
    logic [CNT_W-1:0]   r_cycles;

    logic [OPC_W-1:0]   w_dec_opc;
    logic [OPC_W-1:0]   w_ir_opc;
    logic               w_busy;
    logic               w_launch;
    logic               w_wr_acc;
    logic               w_wr_ram;

    assign w_dec_opc = instr_data[15:11];
    assign w_ir_opc  = r_ir[15:11];
    assign w_busy    = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
    assign w_launch  = start && ((r_state == S_IDLE) || (r_state == S_HALT));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start only matters when idle or halted
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = (w_dec_opc == OPC_HLT) ? S_HALT : S_EXEC;
            S_EXEC:   w_next = S_FETCH;
            S_HALT:   if (start) w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    // PC, instruction register and saturating cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_cycles <= '0;
        end else if (w_launch) begin
            r_pc     <= '0;
            r_cycles <= '0;
        end else begin
            if (w_busy && (r_cycles != {CNT_W{1'b1}})) begin
                r_cycles <= r_cycles + CNT_W'(1);
            end
            if (r_state == S_DECODE) begin
                r_ir <= instr_data;
            end
            if (r_state == S_EXEC) begin
                r_pc <= r_pc + PC_W'(1);
            end
        end
    end

    // Datapath controls; DECODE looks at the memory word directly since IR is still loading
    always_comb begin
        data_addr = '0;
        rd_ram    = 1'b0;
        sel_a     = 2'b00;
        sel_b     = 1'b0;
        op        = 1'b0;
        w_wr_acc  = 1'b0;
        w_wr_ram  = 1'b0;
        case (r_state)
            S_DECODE: begin
                data_addr = PC_W'(instr_data[OPR_W-1:0]);
                rd_ram    = (w_dec_opc == OPC_LD) || (w_dec_opc == OPC_ADD) ||
                            (w_dec_opc == OPC_SUB);
            end
            S_EXEC: begin
                data_addr = PC_W'(r_ir[OPR_W-1:0]);
                case (w_ir_opc)
                    OPC_STO:  w_wr_ram = 1'b1;
                    OPC_LD:   w_wr_acc = 1'b1;
                    OPC_LDI:  begin sel_a = 2'b01; w_wr_acc = 1'b1; end
                    OPC_ADD:  begin sel_a = 2'b10; w_wr_acc = 1'b1; end
                    OPC_ADDI: begin sel_a = 2'b10; sel_b = 1'b1; w_wr_acc = 1'b1; end
                    OPC_SUB:  begin sel_a = 2'b10; op = 1'b1; w_wr_acc = 1'b1; end
                    OPC_SUBI: begin sel_a = 2'b10; sel_b = 1'b1; op = 1'b1; w_wr_acc = 1'b1; end
                    default:  ;
                endcase
            end
            default: ;
        endcase
    end

    // A write coinciding with reset must never reach the accumulator or RAM
    assign wr_acc    = w_wr_acc & ~reset;
    assign wr_ram    = w_wr_ram & ~reset;
    assign prog_addr = r_pc;
    assign busy      = w_busy;
    assign done      = (r_state == S_HALT);
    assign cycles    = r_cycles;

endmodule

// File: tb/tb_bip_control.sv
// Scoreboard bench for bip_control: a program-level model predicts control events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_bip_control;

    localparam int unsigned PC_W  = 11;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned MEM_N = 2048;
    localparam int          CMAX  = 65535;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [15:0]      instr_data;
    logic [PC_W-1:0]  prog_addr;
    logic [PC_W-1:0]  data_addr;
    logic             rd_ram;
    logic             wr_ram;
    logic [1:0]       sel_a;
    logic             sel_b;
    logic             op;
    logic             wr_acc;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycles;

    logic [15:0] pmem [MEM_N];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit       is_done;
        bit       rd;
        bit       wram;
        bit       wacc;
        bit [1:0] sa;
        bit       sb;
        bit       op;
        int       addr;
        int       cyc;
        int       pc;
    } ev_t;

    ev_t exp_q[$];
    bit  done_q = 1'b0;

    bip_control #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .instr_data(instr_data),
        .prog_addr (prog_addr),
        .data_addr (data_addr),
        .rd_ram    (rd_ram),
        .wr_ram    (wr_ram),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .op        (op),
        .wr_acc    (wr_acc),
        .busy      (busy),
        .done      (done),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    // Synchronous program memory, one-cycle read latency
    always @(posedge clk) instr_data <= pmem[prog_addr];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ev_t new_ev();
        ev_t e;
        e.is_done = 1'b0; e.rd = 1'b0; e.wram = 1'b0; e.wacc = 1'b0;
        e.sa = 2'b00; e.sb = 1'b0; e.op = 1'b0;
        e.addr = 0; e.cyc = 0; e.pc = 0;
        return e;
    endfunction

    function automatic logic [15:0] ins(input int opc, input int opr);
        return {5'(opc), 11'(opr)};
    endfunction

    // Program-level reference: walk the program, emit the observable events in order
    task automatic model_run(output int cyc_out);
        int pc = 0;
        int cyc = 0;
        int opc;
        int opr;
        ev_t e;
        cyc_out = 0;
        for (int n = 0; n < 4096; n++) begin
            opc = int'(pmem[pc][15:11]);
            opr = int'(pmem[pc][10:0]);
            cyc += 2;
            if (opc == 0) begin
                e = new_ev();
                e.is_done = 1'b1;
                e.cyc = (cyc > CMAX) ? CMAX : cyc;
                e.pc = pc;
                exp_q.push_back(e);
                cyc_out = cyc;
                return;
            end
            if (opc == 2 || opc == 4 || opc == 6) begin
                e = new_ev();
                e.rd = 1'b1;
                e.addr = opr;
                exp_q.push_back(e);
            end
            cyc += 1;
            e = new_ev();
            e.addr = opr;
            case (opc)
                1: e.wram = 1'b1;
                2: begin e.wacc = 1'b1; e.sa = 2'd0; end
                3: begin e.wacc = 1'b1; e.sa = 2'd1; end
                4: begin e.wacc = 1'b1; e.sa = 2'd2; end
                5: begin e.wacc = 1'b1; e.sa = 2'd2; e.sb = 1'b1; end
                6: begin e.wacc = 1'b1; e.sa = 2'd2; e.op = 1'b1; end
                7: begin e.wacc = 1'b1; e.sa = 2'd2; e.sb = 1'b1; e.op = 1'b1; end
                default: ;
            endcase
            if (e.wacc || e.wram) exp_q.push_back(e);
            pc = (pc + 1) % MEM_N;
        end
        cyc_out = cyc;
    endtask

    task automatic monitor_pop(input bit is_done);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: done=%0d rd=%0d wr_ram=%0d wr_acc=%0d addr=%0d, none expected",
                     done, rd_ram, wr_ram, wr_acc, data_addr);
            return;
        end
        e = exp_q.pop_front();
        if (e.is_done != is_done) begin
            errors++;
            $display("FAIL event_kind: got done=%0d expected done=%0d", is_done, e.is_done);
            return;
        end
        if (is_done) begin
            chk("done_cycles", longint'(cycles), longint'(e.cyc));
            chk("done_pc", longint'(prog_addr), longint'(e.pc));
        end else begin
            chk("ev_rd_ram", longint'(rd_ram), longint'(e.rd));
            chk("ev_wr_ram", longint'(wr_ram), longint'(e.wram));
            chk("ev_wr_acc", longint'(wr_acc), longint'(e.wacc));
            chk("ev_sel_a", longint'(sel_a), longint'(e.sa));
            chk("ev_sel_b", longint'(sel_b), longint'(e.sb));
            chk("ev_op", longint'(op), longint'(e.op));
            chk("ev_data_addr", longint'(data_addr), longint'(e.addr));
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (!wr_acc && !wr_ram)
                chk("ctrl_quiet", longint'({sel_a, sel_b, op}), 0);
            if (rd_ram || wr_acc || wr_ram) monitor_pop(1'b0);
            if (done && !done_q) monitor_pop(1'b1);
        end
        done_q = done;
    end

    task automatic clear_mem();
        for (int i = 0; i < MEM_N; i++) pmem[i] = 16'h0000;
    endtask

    // Pulse start, verify launch, wait for done; optionally spray ignored starts mid-run
    task automatic run_prog(input int exp_cyc, input bit inject);
        int n;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", longint'(busy), 1);
        chk("done_cleared", longint'(done), 0);
        chk("launch_pc", longint'(prog_addr), 0);
        n = 1;
        while (!done && n < 400) begin
            if (inject) start = busy && ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        chk("run_latency", longint'(n), longint'(exp_cyc + 1));
        chk("busy_low_in_halt", longint'(busy), 0);
        @(negedge clk); #1;
        chk("queue_drained", longint'(exp_q.size()), 0);
    endtask

    initial begin
        int ec;
        int n;
        int len;
        reset = 1'b1;
        start = 1'b1;
        clear_mem();

        // Reset with start held high: must stay idle with all outputs zero
        @(posedge clk); #1;
        start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        chk("reset_outputs", longint'({prog_addr, data_addr, rd_ram, wr_ram, sel_a, sel_b,
                                        op, wr_acc, busy, done, cycles}), 0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", longint'({busy, done, cycles}), 0);

        // LDI 5, ADDI 3, STO 7, HLT
        clear_mem();
        pmem[0] = ins(3, 5); pmem[1] = ins(5, 3); pmem[2] = ins(1, 7); pmem[3] = ins(0, 0);
        model_run(ec);
        run_prog(ec, 1'b0);

        // LD 4, SUB 9, SUBI 1, HLT, launched from HALT
        clear_mem();
        pmem[0] = ins(2, 4); pmem[1] = ins(6, 9); pmem[2] = ins(7, 1); pmem[3] = ins(0, 0);
        model_run(ec);
        run_prog(ec, 1'b1);

        // Random programs with stray start pulses during the run
        for (int p = 0; p < 10; p++) begin
            clear_mem();
            len = $urandom_range(1, 18);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) pmem[i] = ins($urandom_range(8, 31), $urandom_range(0, 2047));
                else                           pmem[i] = ins($urandom_range(1, 7), $urandom_range(0, 2047));
            end
            pmem[len] = ins(0, $urandom_range(0, 2047));
            model_run(ec);
            run_prog(ec, 1'b1);
        end

        // Reset during EXEC of ADD: write masked, everything back to zero
        clear_mem();
        pmem[0] = ins(3, 2); pmem[1] = ins(4, 5); pmem[2] = ins(0, 0);
        model_run(ec);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(sel_a == 2'b10 && !sel_b && !op) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("add_exec_reached", longint'(n < 50), 1);
        reset = 1'b1;
        #1;
        chk("reset_masks_wr_acc", longint'(wr_acc), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        chk("reset_mid_run", longint'({busy, done, prog_addr, cycles}), 0);
        @(posedge clk); #1;
        chk("idle_holds", longint'({busy, done}), 0);

        // Endless NOP loop: PC wrap at 2047 and cycle-counter saturation
        for (int i = 0; i < MEM_N; i++) pmem[i] = ins($urandom_range(8, 31), $urandom_range(0, 2047));
        pmem[MEM_N-1] = ins(31, $urandom_range(0, 2047));
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (prog_addr != PC_W'(MEM_N - 1) && n < 7000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_pc_2047", longint'(prog_addr), longint'(MEM_N - 1));
        n = 0;
        while (prog_addr == PC_W'(MEM_N - 1) && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pc_wrap_to_0", longint'(prog_addr), 0);
        chk("cycles_at_wrap", longint'(cycles), longint'(3 * MEM_N));
        n = 0;
        while (cycles != CNT_W'(CMAX) && n < 70000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cycles_reach_max", longint'(cycles), CMAX);
        repeat (20) @(posedge clk);
        #1;
        chk("cycles_saturated", longint'(cycles), CMAX);
        chk("still_busy", longint'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("final_reset", longint'({busy, done, prog_addr, cycles}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
